// File: rtl/reflet_interrupt_ctrl.sv
// Reflet interrupt controller: latches 4 event sources, masks and prioritises
// them, and presents one request at a time to the CPU with an ack handshake.
//
// Ports:
//   clk       system clock, all state on rising edge
//   reset     asynchronous active-low reset
//   enable    bus access qualifier
//   addr      bus address (base_addr_size bits)
//   write_en  bus write strobe
//   data_in   bus write data
//   data_out  bus read data, 0 when not selected
//   irq_src   one-cycle event pulses, bit 0 highest priority
//   irq_ack   CPU acknowledge of the presented request
//   irq_out   interrupt request to the CPU
//   irq_id    index of the presented source
//
// Register map (offset from base_addr):
//   0 MASK     rw, bits 3:0
//   1 PENDING  read, write 1 to clear
//   2 CTRL     rw, bit 0 global enable
//   3 MISSED   read, any write clears
module reflet_interrupt_ctrl #(
    parameter int                        base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr      = 16'hFF20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic [3:0]                irq_src,
    input  logic                      irq_ack,
    output logic                      irq_out,
    output logic [1:0]                irq_id
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
    } state_t;

    state_t state;

    logic [3:0] mask;
    logic [3:0] pending;
    logic       ctrl;
    logic [7:0] missed;

    logic [base_addr_size-1:0] rel;
    logic                      sel;
    logic [1:0]                off;
    logic                      wr;
    logic [3:0]                clr;
    logic                      miss;
    logic [3:0]                elig;
    logic [1:0]                low_id;

    // Subtracting first keeps the window check free of base_addr+4 overflow.
    assign rel = addr - base_addr;
    assign sel = enable && (addr >= base_addr)
                 && (rel[base_addr_size-1:2] == '0);
    assign off = rel[1:0];
    assign wr  = sel && write_en;

    assign elig = pending & mask & {4{ctrl}};

    always_comb begin
        clr = '0;
        if (wr && off == 2'd1) begin
            clr = data_in[3:0];
        end
        if (state == REQ && irq_ack) begin
            clr[irq_id] = 1'b1;
        end
    end

    // A cleared bit frees its slot, so a new pulse on it is not a miss.
    assign miss = |(irq_src & pending & ~clr);

    always_comb begin
        low_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (elig[i]) begin
                low_id = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask    <= '0;
            pending <= '0;
            ctrl    <= 1'b0;
            missed  <= '0;
        end else begin
            // New events win over a same-cycle clear.
            pending <= (pending & ~clr) | irq_src;
            if (wr && off == 2'd0) begin
                mask <= data_in[3:0];
            end
            if (wr && off == 2'd2) begin
                ctrl <= data_in[0];
            end
            if (wr && off == 2'd3) begin
                missed <= '0;
            end else if (miss && missed != 8'hFF) begin
                missed <= missed + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            irq_out <= 1'b0;
            irq_id  <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|elig) begin
                        state   <= REQ;
                        irq_out <= 1'b1;
                        irq_id  <= low_id;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state   <= ACK;
                        irq_out <= 1'b0;
                    end else if (!elig[irq_id]) begin
                        state   <= IDLE;
                        irq_out <= 1'b0;
                    end
                end
                ACK: begin
                    state   <= IDLE;
                    irq_out <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    irq_out <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (sel) begin
            unique case (off)
                2'd0: data_out = {4'b0, mask};
                2'd1: data_out = {4'b0, pending};
                2'd2: data_out = {7'b0, ctrl};
                2'd3: data_out = missed;
                default: data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_interrupt_ctrl.sv
// Testbench for reflet_interrupt_ctrl: directed scenarios followed by a
// randomized run checked against a behavioural model.
module tb_reflet_interrupt_ctrl;

    localparam logic [15:0] BASE = 16'hFF20;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        enable   = 1'b0;
    logic [15:0] addr     = '0;
    logic        write_en = 1'b0;
    logic [7:0]  data_in  = '0;
    logic [3:0]  irq_src  = '0;
    logic        irq_ack  = 1'b0;
    logic [7:0]  data_out;
    logic        irq_out;
    logic [1:0]  irq_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase 0 waiting, 1 presenting, 2 cooling down.
    bit [3:0] m_mask;
    bit [3:0] m_pend;
    bit       m_ctrl;
    int       m_missed;
    int       m_phase;
    int       m_id;

    reflet_interrupt_ctrl #(
        .base_addr_size(16),
        .base_addr     (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .addr    (addr),
        .write_en(write_en),
        .data_in (data_in),
        .data_out(data_out),
        .irq_src (irq_src),
        .irq_ack (irq_ack),
        .irq_out (irq_out),
        .irq_id  (irq_id)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mask   = '0;
        m_pend   = '0;
        m_ctrl   = 1'b0;
        m_missed = 0;
        m_phase  = 0;
        m_id     = 0;
    endtask

    task automatic model_step(input bit en, input logic [15:0] a,
                              input bit we, input logic [7:0] d,
                              input logic [3:0] src, input bit ack);
        bit [3:0] clrv;
        bit [3:0] elig;
        bit       hit;
        bit       wr;
        int       off;
        int       ai;
        int       bi;
        ai  = int'(a);
        bi  = int'(BASE);
        wr  = en && we && ai >= bi && ai < bi + 4;
        off = wr ? ai - bi : -1;
        elig = m_ctrl ? (m_pend & m_mask) : 4'b0;
        clrv = '0;
        if (off == 1) clrv = d[3:0];
        if (m_phase == 1 && ack) clrv[m_id] = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (src[i] && m_pend[i] && !clrv[i]) hit = 1'b1;
        end
        case (m_phase)
            0: begin
                if (elig != 0) begin
                    for (int i = 3; i >= 0; i--) begin
                        if (elig[i]) m_id = i;
                    end
                    m_phase = 1;
                end
            end
            1: begin
                if (ack) m_phase = 2;
                else if (!elig[m_id]) m_phase = 0;
            end
            default: m_phase = 0;
        endcase
        m_pend = (m_pend & ~clrv) | src;
        if (off == 3) m_missed = 0;
        else if (hit && m_missed < 255) m_missed = m_missed + 1;
        if (off == 0) m_mask = d[3:0];
        if (off == 2) m_ctrl = d[0];
    endtask

    function automatic logic [7:0] m_reg(input int off);
        case (off)
            0: return {4'b0, m_mask};
            1: return {4'b0, m_pend};
            2: return {7'b0, m_ctrl};
            default: return 8'(m_missed);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit en, input logic [15:0] a, input bit we,
                       input logic [7:0] d, input logic [3:0] src,
                       input bit ack);
        enable   = en;
        addr     = a;
        write_en = we;
        data_in  = d;
        irq_src  = src;
        irq_ack  = ack;
        @(posedge clk);
        model_step(en, a, we, d, src, ack);
        #1;
        enable   = 1'b0;
        write_en = 1'b0;
        data_in  = '0;
        irq_src  = '0;
        irq_ack  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        cyc(1'b1, BASE + {14'b0, off}, 1'b1, d, 4'b0, 1'b0);
    endtask

    task automatic pulse(input logic [3:0] src);
        cyc(1'b0, 16'h0, 1'b0, 8'h0, src, 1'b0);
    endtask

    task automatic ack_c();
        cyc(1'b0, 16'h0, 1'b0, 8'h0, 4'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pulse(4'b0);
    endtask

    task automatic rd(input bit en, input logic [15:0] a,
                      output logic [7:0] v);
        enable   = en;
        addr     = a;
        write_en = 1'b0;
        #1;
        v      = data_out;
        enable = 1'b0;
    endtask

    task automatic rchk(input string tag, input logic [1:0] off,
                        input logic [7:0] exp);
        logic [7:0] v;
        rd(1'b1, BASE + {14'b0, off}, v);
        chk(tag, v, exp);
    endtask

    task automatic ochk(input string tag, input logic o,
                        input logic [1:0] id);
        chk({tag, "_out"}, 8'(irq_out), 8'(o));
        chk({tag, "_id"}, 8'(irq_id), 8'(id));
    endtask

    initial begin
        logic [7:0] v;
        model_reset();

        // Reset state, read while reset is held
        #2;
        ochk("rst", 1'b0, 2'd0);
        rchk("rst_mask", 2'd0, 8'h00);
        rchk("rst_pend", 2'd1, 8'h00);
        rchk("rst_ctrl", 2'd2, 8'h00);
        #1;
        reset = 1'b1;

        // Single request, latency, ack and gap
        wr(2'd0, 8'hFF);
        rchk("mask_rw", 2'd0, 8'h0F);
        wr(2'd2, 8'hFF);
        rchk("ctrl_rw", 2'd2, 8'h01);
        pulse(4'b0100);
        rchk("p4_pend", 2'd1, 8'h04);
        chk("p4_early", 8'(irq_out), 8'h00);
        idle(1);
        ochk("p4_req", 1'b1, 2'd2);
        ack_c();
        rchk("p4_ackpend", 2'd1, 8'h00);
        chk("p4_gap", 8'(irq_out), 8'h00);
        idle(2);
        chk("p4_quiet", 8'(irq_out), 8'h00);

        // Priority between simultaneous sources
        pulse(4'b1010);
        idle(1);
        ochk("pri_first", 1'b1, 2'd1);
        ack_c();
        chk("pri_gap", 8'(irq_out), 8'h00);
        rchk("pri_pend", 2'd1, 8'h08);
        idle(1);
        chk("pri_gap2", 8'(irq_out), 8'h00);
        idle(1);
        ochk("pri_second", 1'b1, 2'd3);
        ack_c();
        idle(2);

        // Masked source, missed counting, unmask, MISSED clear
        wr(2'd0, 8'h00);
        pulse(4'b0001);
        pulse(4'b0001);
        rchk("miss_pend", 2'd1, 8'h01);
        rchk("miss_cnt", 2'd3, 8'h01);
        idle(2);
        chk("miss_noirq", 8'(irq_out), 8'h00);
        wr(2'd0, 8'h01);
        idle(1);
        ochk("unmask_req", 1'b1, 2'd0);
        wr(2'd3, 8'h5A);
        rchk("miss_clr", 2'd3, 8'h00);
        ack_c();
        idle(2);

        // Set beats a same-cycle write-1-clear; ack ignored in IDLE
        wr(2'd2, 8'h00);
        pulse(4'b0001);
        cyc(1'b1, BASE + 16'd1, 1'b1, 8'h01, 4'b0001, 1'b0);
        rchk("setclr_pend", 2'd1, 8'h01);
        rchk("setclr_miss", 2'd3, 8'h00);
        ack_c();
        rchk("idle_ack", 2'd1, 8'h01);
        wr(2'd1, 8'h0F);
        rchk("w1c", 2'd1, 8'h00);

        // Global disable drops the request, then reset mid-request
        wr(2'd0, 8'h0F);
        wr(2'd2, 8'h01);
        pulse(4'b0010);
        idle(1);
        ochk("dis_req", 1'b1, 2'd1);
        wr(2'd2, 8'h00);
        idle(1);
        chk("dis_drop", 8'(irq_out), 8'h00);
        rchk("dis_keep", 2'd1, 8'h02);
        wr(2'd2, 8'h01);
        idle(1);
        ochk("rereq", 1'b1, 2'd1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        ochk("mid_rst", 1'b0, 2'd0);
        rchk("mid_rst_mask", 2'd0, 8'h00);
        rchk("mid_rst_pend", 2'd1, 8'h00);
        rchk("mid_rst_ctrl", 2'd2, 8'h00);
        #1;
        reset = 1'b1;

        // Address decode and MISSED saturation
        pulse(4'b1111);
        rd(1'b0, BASE + 16'd1, v);
        chk("dec_noen", v, 8'h00);
        rd(1'b1, BASE + 16'd4, v);
        chk("dec_above", v, 8'h00);
        rd(1'b1, BASE - 16'd1, v);
        chk("dec_below", v, 8'h00);
        rchk("dec_in", 2'd1, 8'h0F);
        for (int i = 0; i < 254; i++) pulse(4'b0001);
        rchk("sat_254", 2'd3, 8'hFE);
        for (int i = 0; i < 46; i++) pulse(4'b0001);
        rchk("sat_300", 2'd3, 8'hFF);
        wr(2'd3, 8'h00);
        rchk("sat_clr", 2'd3, 8'h00);

        // Randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            bit          en;
            bit          ack;
            logic [15:0] a;
            logic [7:0]  d;
            logic [3:0]  s;
            en  = ($urandom % 4) == 0;
            a   = BASE + 16'($urandom % 6);
            d   = 8'($urandom);
            s   = (($urandom % 3) == 0) ? 4'($urandom) : 4'b0;
            ack = ($urandom % 2) == 1;
            cyc(en, a, 1'b1, d, s, ack);
            chk("rnd_out", 8'(irq_out), (m_phase == 1) ? 8'h01 : 8'h00);
            chk("rnd_id", 8'(irq_id), 8'(m_id));
            for (int o = 0; o < 4; o++) begin
                rchk("rnd_reg", 2'(o), m_reg(o));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reflet_interrupt_ctrl.md
REFLET_INTERRUPT_CTRL -- requirements
Module: reflet_interrupt_ctrl

Interface
REQ-001 SHALL have parameter base_addr_size, default 16, meaning the bus address width.
REQ-002 SHALL have parameter base_addr, default 16'hFF20, meaning the address of register offset 0.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  bus access qualifier.
REQ-006 SHALL have port addr  input  base_addr_size  bus address.
REQ-007 SHALL have port write_en  input  1  bus write strobe.
REQ-008 SHALL have port data_in  input  8  bus write data.
REQ-009 SHALL have port data_out  output  8  bus read data; 0 when not selected, so bus outputs can be ORed.
REQ-010 SHALL have port irq_src  input  4  one-cycle event pulses from timers and other peripherals; bit 0 has highest priority.
REQ-011 SHALL have port irq_ack  input  1  CPU acknowledge pulse for the presented request.
REQ-012 SHALL have port irq_out  output  1  interrupt request to the CPU.
REQ-013 SHALL have port irq_id  output  2  index of the presented source.

Function
REQ-014 SHALL be selected when enable=1 and base_addr <= addr < base_addr+4, with offset = addr-base_addr (2 bits).
REQ-015 SHALL map offset 0 to MASK (rw, bits 3:0 per-source enable, bits 7:4 read 0), offset 1 to PENDING (bits 3:0; read; writing 1 to a bit clears it), offset 2 to CTRL (rw, bit 0 global enable, others read 0) and offset 3 to MISSED (read-only; any write clears it to 0).
REQ-016 SHALL return register reads combinationally in the same cycle; registers update on the clock edge that samples write_en=1.
REQ-017 SHALL set PENDING[i] on the clock edge that samples irq_src[i]=1, regardless of MASK.
REQ-018 SHALL give set priority over a same-cycle write-1-clear or ack-clear of the same bit.
REQ-019 SHALL increment MISSED by 1 when irq_src[i]=1 arrives while PENDING[i] is already 1 and no clear of bit i occurs in that cycle; MISSED saturates at 8'hFF; several simultaneous misses count as 1.
REQ-020 SHALL define eligible = PENDING & MASK, qualified by CTRL[0].
REQ-021 SHALL implement three states: IDLE, REQ and ACK.
REQ-022 IDLE: irq_out=0; if any bit of eligible is set, SHALL latch irq_id = lowest eligible index and move to REQ on the next edge.
REQ-023 REQ: SHALL hold irq_out=1 and irq_id stable.
REQ-024 REQ on irq_ack=1: SHALL clear PENDING[irq_id] and move to ACK.
REQ-025 REQ with the presented bit no longer eligible (cleared by software, masked, or global disable) and no ack: SHALL return to IDLE with irq_out=0.
REQ-026 ACK: SHALL hold irq_out=0 for exactly one cycle, then go to IDLE; this guarantees a 1-cycle gap between requests.
REQ-027 SHALL ignore irq_ack in IDLE and ACK.
REQ-028 Latency: a pulse on an enabled idle source SHALL reach irq_out=1 two edges after it is sampled (PENDING edge, then REQ edge).

Reset
REQ-029 SHALL, while reset=0, immediately force MASK=0, PENDING=0, CTRL=0, MISSED=0, state=IDLE, irq_out=0 and irq_id=0, including mid-request.
REQ-030 SHALL keep data_out purely combinational, so it reads 0 for all registers during reset when selected.

Verification
REQ-031 MASK=4'hF, CTRL=1; pulse irq_src=4'b0100 -> PENDING=4'h4, then irq_out=1 and irq_id=2 two edges after the pulse; irq_ack -> PENDING=0, irq_out low for one cycle.
REQ-032 Pulse irq_src=4'b1010 in one cycle with all enabled -> irq_id=1 first; after ack and the gap -> irq_id=3.
REQ-033 MASK=0, pulse src0 twice -> PENDING=1, MISSED=1, irq_out stays 0; set MASK=1 -> request appears; write any value to offset 3 -> MISSED=0.
REQ-034 irq_src[0] pulse in the same cycle as a write of 8'h01 to PENDING -> PENDING[0]=1 and MISSED unchanged.
REQ-035 In REQ, write CTRL=0 -> irq_out drops on the next edge and PENDING is retained; assert reset mid-REQ -> all registers 0 and irq_out=0 without waiting for a clock.
REQ-036 Reads at base_addr+4 or with enable=0 -> data_out=0; 300 missed events -> MISSED=8'hFF.
